read_prefetch_buffer: RTL

Single-clock, parametrised prefetch buffer between the memory read port and the downlink byte serialiser. It issues one-word read requests as soon as enough rows have been written, holds up to DEPTH words, and serves them out one byte per NEXT_BYTE strobe, least-significant byte first. It adds a synchronous byte strobe, a prefetch FIFO, read addressing, a data-valid handshake and underrun flagging.

---
 rtl/read_buffer_pkg.sv | 17 +
 rtl/sync_word_fifo.sv | 73 +++++++
 rtl/read_prefetch_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/read_buffer_pkg.sv
// Shared definitions for the read-side prefetch buffer: default widths,
// the start threshold and the read FSM state encoding.
package read_buffer_pkg;

  localparam int WORD_W_DEF       = 16;
  localparam int BYTE_W_DEF       = 8;
  localparam int ADDR_W_DEF       = 13;
  localparam int DEPTH_DEF        = 4;
  localparam int START_THRESH_DEF = 3;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    IDLE       = 2'd1,
    WAIT_DATA  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with show-ahead head output and occupancy count.
// A push and a pop in the same cycle are both honoured; a push into a full
// FIFO is accepted only when a pop frees the slot in that same cycle.
module sync_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against occupancy and compute next pointers and count.
  always_comb begin
    pop_ok_s  = pop && (count_q != CNT_W'(0));
    push_ok_s = push && ((count_q != CNT_W'(DEPTH)) || pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage; contents are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/read_prefetch_buffer.sv
// Prefetch buffer between the memory read port and the byte serialiser.
// Issues one outstanding single-word read at a time once enough rows exist,
// buffers up to DEPTH words and hands them out LSB-first one byte per strobe.
module read_prefetch_buffer
  import read_buffer_pkg::*;
#(
  parameter int WORD_W       = WORD_W_DEF,
  parameter int BYTE_W       = BYTE_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int START_THRESH = START_THRESH_DEF
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET,
  input  logic              NEXT_BYTE,
  output logic [BYTE_W-1:0] BYTE_OUT,
  output logic              BYTE_VALID,
  output logic              READ_CMD,
  output logic [ADDR_W-1:0] READ_ADDR,
  input  logic [WORD_W-1:0] DATA_READ,
  input  logic              DATA_VALID,
  input  logic [ADDR_W-1:0] ROW_WRITE,
  output logic              UNDERRUN
);

  localparam int LANES  = WORD_W / BYTE_W;
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] read_addr_q, read_addr_d;
  logic              read_cmd_q, read_cmd_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              underrun_q, underrun_d;

  logic [ADDR_W-1:0]            avail_s;
  logic                         push_s;
  logic                         pop_s;
  logic [WORD_W-1:0]            head_s;
  logic [CNT_W-1:0]             count_s;
  logic [LANES-1:0][BYTE_W-1:0] head_lanes_s;
  logic                         byte_valid_s;
  logic [BYTE_W-1:0]            byte_out_s;

  sync_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK_48MHZ),
    .rst_n     (RESET),
    .push      (push_s),
    .push_data (DATA_READ),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Rows written but not yet fetched; modular so the writer may wrap first.
  assign avail_s      = ROW_WRITE - rd_addr_q;
  assign head_lanes_s = head_s;
  assign byte_valid_s = (count_s != CNT_W'(0));

  // Read FSM: gate on start threshold, issue one read, wait for its data.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    read_addr_d = read_addr_q;
    read_cmd_d  = 1'b0;
    push_s      = 1'b0;
    case (state_q)
      WAIT_START: begin
        if (ROW_WRITE >= ADDR_W'(START_THRESH)) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_START;
        end
      end
      IDLE: begin
        // Slot is judged on the registered count: only one read can be in flight.
        if ((avail_s != ADDR_W'(0)) && (count_s < CNT_W'(DEPTH))) begin
          state_d     = WAIT_DATA;
          read_cmd_d  = 1'b1;
          read_addr_d = rd_addr_q;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_DATA: begin
        if (DATA_VALID) begin
          state_d   = IDLE;
          push_s    = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end else begin
          state_d = WAIT_DATA;
        end
      end
      default: begin
        state_d = WAIT_START;
      end
    endcase
  end

  // Byte strobe handling: advance lane, pop on last lane, flag empty reads.
  always_comb begin
    lane_d     = lane_q;
    underrun_d = underrun_q;
    pop_s      = 1'b0;
    if (NEXT_BYTE) begin
      if (byte_valid_s) begin
        if (lane_q == LANE_W'(LANES - 1)) begin
          pop_s  = 1'b1;
          lane_d = LANE_W'(0);
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end else begin
        underrun_d = 1'b1;
      end
    end else begin
      lane_d = lane_q;
    end
  end

  // Current byte from the FIFO head; forced to zero while nothing is buffered.
  always_comb begin
    if (byte_valid_s) begin
      byte_out_s = head_lanes_s[lane_q];
    end else begin
      byte_out_s = BYTE_W'(0);
    end
  end

  // State, address, lane and flag registers with synchronous active-low reset.
  always_ff @(posedge CLK_48MHZ) begin
    if (!RESET) begin
      state_q     <= WAIT_START;
      rd_addr_q   <= ADDR_W'(0);
      read_addr_q <= ADDR_W'(0);
      read_cmd_q  <= 1'b0;
      lane_q      <= LANE_W'(0);
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      read_addr_q <= read_addr_d;
      read_cmd_q  <= read_cmd_d;
      lane_q      <= lane_d;
      underrun_q  <= underrun_d;
    end
  end

  assign BYTE_OUT   = byte_out_s;
  assign BYTE_VALID = byte_valid_s;
  assign READ_CMD   = read_cmd_q;
  assign READ_ADDR  = read_addr_q;
  assign UNDERRUN   = underrun_q;

endmodule
